pixel_write_arbiter: RTL and testbench
======================================

// Module: pixel_write_arbiter
// PURPOSE
// - Owns pixel_bram write port A (sys_clk domain) and shares it between the raytracing_controller pixel stream and a frame-clear engine.
// - Buffers ray pixels in a small FIFO and computes addr = FRAME_WIDTH*y + x.
// - On request, fills the whole frame with a background colour, one write per cycle.
// - Sits between raytracing_controller outputs (valid_out/pixel_x_out/pixel_y_out/pixel_value) and pixel_bram wea/addra/dina.
// PARAMETERS
// - FRAME_WIDTH   512  pixels per line; address stride
// - FRAME_HEIGHT  384  lines per frame
// - ADDR_BITS     18   BRAM address width
// - COLOR_BITS    16   padded pixel width
// - FIFO_DEPTH    4    ray pixel FIFO entries; power of 2, >=2
// PORTS
// - clk          in   1           system clock (sys_clk)
// - rst_n        in   1           asynchronous reset, active-low
// - clear_req    in   1           one-cycle pulse: start frame clear
// - clear_color  in   COLOR_BITS  fill value; sampled with clear_req
// - clear_busy   out  1           clear in progress
// - ray_valid    in   1           ray pixel offered
// - ray_ready    out  1           pixel accepted when ray_valid && ray_ready
// - ray_x        in   16          screen x
// - ray_y        in   16          screen y
// - ray_pixel    in   COLOR_BITS  pixel value
// - bram_we      out  1           BRAM write enable (registered)
// - bram_addr    out  ADDR_BITS   BRAM address (registered)
// - bram_din     out  COLOR_BITS  BRAM data (registered)
// BEHAVIOUR
// - Reset (async, rst_n=0): FIFO empty, state IDLE, clear counter 0; all outputs 0; ray_ready=1 from first clk after release.
// - States:
//   - IDLE: FIFO empty; no writes.
//   - RAY: FIFO non-empty; pop one entry per cycle.
//   - CLEAR: address counter runs 0..FRAME_WIDTH*FRAME_HEIGHT-1.
// - Transitions:
//   - IDLE<->RAY follows FIFO occupancy.
//   - Any state -> CLEAR on clear_req when clear_busy=0.
//   - CLEAR -> IDLE after the write to the last address.
// - Ray path:
//   - push when ray_valid && ray_ready; ray_ready = !full && state!=CLEAR.
//   - A push on a full FIFO is never allowed, even with a simultaneous pop.
//   - Pop stage computes FRAME_WIDTH*y + x, truncated to ADDR_BITS; output regs update next edge.
//   - Latency: handshake at edge t into an empty FIFO -> bram_we=1 in the cycle after edge t+2.
//   - Throughput: 1 pixel/cycle sustained.
// - Out of range (x>=FRAME_WIDTH or y>=FRAME_HEIGHT): pixel accepted, popped, no write (bram_we=0 that cycle).
// - Clear:
//   - clear_req sampled high -> FIFO flushed (pending entries are the stale frame and are dropped); clear_color latched.
//   - clear_busy=1 from the next cycle.
//   - bram_we=1, bram_din=clear_color, bram_addr=0,1,...,196607 on consecutive cycles (FRAME_WIDTH*FRAME_HEIGHT cycles).
//   - clear_busy falls the cycle after the last write; ray_ready rises the same cycle.
// - Ignored/edge cases:
//   - clear_req while clear_busy=1 is ignored (no restart, colour unchanged).
//   - clear_req in the same cycle as a ray handshake: the clear wins; that pixel is not accepted (ray_ready forced 0 that cycle).
//   - Reset mid-clear or mid-drain: immediate abort; bram_we=0 asynchronously; no partial-state resume.
// CONFIGURATION
// - PWA_STATS_EN defined: adds outputs
//   - frame_pixels [ADDR_BITS-1:0]: count of in-range ray writes; cleared to 0 when a clear starts, wraps at 2^ADDR_BITS.
//   - oob_count [15:0]: count of dropped out-of-range pixels; saturates at 16'hFFFF, cleared only by reset.
//   - Both are 0 at reset.
// - PWA_STATS_EN undefined: these ports and counters do not exist. Write behaviour is identical.
// TESTING
// - Single pixel: x=3, y=2, pixel=16'h0ABC into idle block -> one cycle of bram_we=1, addr=1027, din=16'h0ABC, 2 cycles after the handshake.
// - Burst: 8 back-to-back pixels with ray_valid held high -> ray_ready stays 1; 8 consecutive writes, addresses in order; no gaps after the first.
// - Backpressure: force 5 pushes while output blocked by CLEAR -> ray_ready=0; no pixel lost or duplicated after the clear ends.
// - Clear: clear_req with colour 16'h0F00 -> clear_busy high for exactly 196608 cycles; addrs 0..196607 each written once with 16'h0F00; second clear_req mid-clear ignored.
// - OOB: x=512, y=0 and x=0, y=384 -> no bram_we; with PWA_STATS_EN, oob_count=2 and frame_pixels unchanged.
// - Reset: assert rst_n=0 at clear address 1000 -> bram_we=0 and clear_busy=0 immediately; after release, ray_ready=1 and FIFO empty.

Source files
------------

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: owns pixel_bram write port A and shares it between the
// ray pixel stream (small FIFO + address compute) and a full-frame clear engine.
// Optional build macro PWA_STATS_EN adds frame_pixels / oob_count statistics.
module pixel_write_arbiter #(
  parameter int unsigned FRAME_WIDTH  = 512,
  parameter int unsigned FRAME_HEIGHT = 384,
  parameter int unsigned ADDR_BITS    = 18,
  parameter int unsigned COLOR_BITS   = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  input  logic [COLOR_BITS-1:0] clear_color,
  output logic                  clear_busy,
  input  logic                  ray_valid,
  output logic                  ray_ready,
  input  logic [15:0]           ray_x,
  input  logic [15:0]           ray_y,
  input  logic [COLOR_BITS-1:0] ray_pixel,
  output logic                  bram_we,
  output logic [ADDR_BITS-1:0]  bram_addr,
  output logic [COLOR_BITS-1:0] bram_din
`ifdef PWA_STATS_EN
  ,
  output logic [ADDR_BITS-1:0]  frame_pixels,
  output logic [15:0]           oob_count
`endif
);

  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned LAST_ADDR = FRAME_WIDTH * FRAME_HEIGHT - 1;

  typedef struct packed {
    logic [15:0]           x;
    logic [15:0]           y;
    logic [COLOR_BITS-1:0] pix;
  } ray_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_RAY, S_CLEAR} state_t;

  state_t                r_state, w_state_nxt;
  ray_entry_t            r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count, w_count_nxt;
  logic                  r_rdy_en;
  logic [ADDR_BITS-1:0]  r_clr_cnt, w_clr_cnt_nxt;
  logic [COLOR_BITS-1:0] r_clr_color;
  logic                  r_p_vld, r_p_inr;
  logic [ADDR_BITS-1:0]  r_p_addr;
  logic [COLOR_BITS-1:0] r_p_pix;
  logic                  r_bram_we, w_we_nxt;
  logic [ADDR_BITS-1:0]  r_bram_addr, w_addr_nxt;
  logic [COLOR_BITS-1:0] r_bram_din, w_din_nxt;

  logic       w_full, w_empty, w_clr_go, w_push, w_pop, w_ray_wr, w_head_inr;
  ray_entry_t w_head, w_in;

  assign clear_busy = (r_state == S_CLEAR);
  assign w_clr_go   = clear_req && !clear_busy;
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  // A starting clear takes priority over a handshake in the same cycle
  assign ray_ready  = r_rdy_en && !w_full && !clear_busy && !w_clr_go;
  assign w_push     = ray_valid && ray_ready;
  assign w_pop      = !w_empty && !clear_busy && !w_clr_go;
  assign w_ray_wr   = r_p_vld && r_p_inr;
  assign w_in       = '{x: ray_x, y: ray_y, pix: ray_pixel};
  assign w_head     = r_fifo[r_rd_ptr];
  assign w_head_inr = (32'(w_head.x) < FRAME_WIDTH) && (32'(w_head.y) < FRAME_HEIGHT);
  assign w_count_nxt = w_clr_go ? '0 : (r_count + CNT_W'(w_push) - CNT_W'(w_pop));

  assign bram_we   = r_bram_we;
  assign bram_addr = r_bram_addr;
  assign bram_din  = r_bram_din;

  // FIFO storage; contents are don't-care while the occupancy count is zero
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_in;
  end

  // FIFO pointers and occupancy; a starting clear flushes pending entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      r_count  <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_clr_go)   r_rd_ptr <= r_wr_ptr;
      else if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Pop stage: linear address and range check of the FIFO head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_vld  <= 1'b0;
      r_p_inr  <= 1'b0;
      r_p_addr <= '0;
      r_p_pix  <= '0;
    end else begin
      r_p_vld <= w_pop;
      if (w_pop) begin
        r_p_inr  <= w_head_inr;
        r_p_addr <= ADDR_BITS'(32'(FRAME_WIDTH) * 32'(w_head.y) + 32'(w_head.x));
        r_p_pix  <= w_head.pix;
      end
    end
  end

  // Clear colour is captured only when a clear is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_clr_color <= '0;
    else if (w_clr_go) r_clr_color <= clear_color;
  end

  // State, clear counter and registered BRAM port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_clr_cnt   <= '0;
      r_bram_we   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_cnt   <= w_clr_cnt_nxt;
      r_bram_we   <= w_we_nxt;
      r_bram_addr <= w_addr_nxt;
      r_bram_din  <= w_din_nxt;
    end
  end

  // Next state and next BRAM write: clear sweep, else drained ray pixel
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_we_nxt      = 1'b0;
    w_addr_nxt    = r_bram_addr;
    w_din_nxt     = r_bram_din;
    case (r_state)
      S_CLEAR: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = r_clr_cnt;
        w_din_nxt  = r_clr_color;
        if (r_clr_cnt == ADDR_BITS'(LAST_ADDR)) begin
          w_state_nxt   = S_IDLE;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + ADDR_BITS'(1);
        end
      end
      default: begin
        if (w_ray_wr) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = r_p_addr;
          w_din_nxt  = r_p_pix;
        end
        w_state_nxt = (w_count_nxt != '0) ? S_RAY : S_IDLE;
      end
    endcase
    if (w_clr_go) begin
      w_state_nxt   = S_CLEAR;
      w_clr_cnt_nxt = '0;
    end
  end

`ifdef PWA_STATS_EN
  logic [ADDR_BITS-1:0] r_frame_pixels;
  logic [15:0]          r_oob_count;

  // In-range write count per frame, saturating out-of-range drop count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_pixels <= '0;
      r_oob_count    <= '0;
    end else begin
      if (w_clr_go)      r_frame_pixels <= '0;
      else if (w_ray_wr) r_frame_pixels <= r_frame_pixels + ADDR_BITS'(1);
      if (r_p_vld && !r_p_inr && (r_oob_count != 16'hFFFF))
        r_oob_count <= r_oob_count + 16'd1;
    end
  end

  assign frame_pixels = r_frame_pixels;
  assign oob_count    = r_oob_count;
`endif

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter (reduced frame height keeps clears short).
module tb_pixel_write_arbiter;

  localparam int unsigned FW   = 512;
  localparam int unsigned FH   = 4;
  localparam int unsigned AB   = 18;
  localparam int unsigned CB   = 16;
  localparam int unsigned FD   = 4;
  localparam int unsigned NPIX = FW * FH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_req = 1'b0;
  logic [CB-1:0] clear_color = '0;
  logic          clear_busy;
  logic          ray_valid = 1'b0;
  logic          ray_ready;
  logic [15:0]   ray_x = '0;
  logic [15:0]   ray_y = '0;
  logic [CB-1:0] ray_pixel = '0;
  logic          bram_we;
  logic [AB-1:0] bram_addr;
  logic [CB-1:0] bram_din;
`ifdef PWA_STATS_EN
  logic [AB-1:0] frame_pixels;
  logic [15:0]   oob_count;
`endif

  pixel_write_arbiter #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .ADDR_BITS(AB), .COLOR_BITS(CB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
    .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_x(ray_x), .ray_y(ray_y), .ray_pixel(ray_pixel),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din)
`ifdef PWA_STATS_EN
    , .frame_pixels(frame_pixels), .oob_count(oob_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   x;
    logic [15:0]   y;
    logic [CB-1:0] pix;
    logic          we;
    logic [AB-1:0] addr;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  int            busy_cyc, clr_wr, clr_bad, ready_in_busy;
  logic          fall_seen, fall_we, fall_rdy;
  logic [AB-1:0] fall_addr;
  logic [CB-1:0] exp_color;
  logic [AB-1:0] rw_addr[$];
  logic [CB-1:0] rw_din[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One isolated pixel: ready at offer, write exactly two cycles after the handshake
  task automatic send_vec(input vec_t v, input string tag);
    @(negedge clk);
    ray_valid = 1'b1; ray_x = v.x; ray_y = v.y; ray_pixel = v.pix;
    #1;
    check({tag, "_ready"}, 32'(ray_ready), 32'd1);
    @(negedge clk);
    ray_valid = 1'b0;
    #1;
    check({tag, "_we_t0"}, 32'(bram_we), 32'd0);
    @(negedge clk); #1;
    check({tag, "_we_t1"}, 32'(bram_we), 32'd0);
    @(negedge clk); #1;
    check({tag, "_we_t2"}, 32'(bram_we), 32'(v.we));
    if (v.we) begin
      check({tag, "_addr"}, 32'(bram_addr), 32'(v.addr));
      check({tag, "_din"},  32'(bram_din),  32'(v.pix));
    end
    @(negedge clk); #1;
    check({tag, "_we_t3"}, 32'(bram_we), 32'd0);
  endtask

  function automatic void clear_stats();
    busy_cyc = 0; clr_wr = 0; clr_bad = 0; ready_in_busy = 0;
    fall_seen = 1'b0; fall_we = 1'b0; fall_rdy = 1'b0; fall_addr = '0;
    rw_addr.delete(); rw_din.delete();
  endfunction

  // Run n cycles, offering n_offer pixels (x=10+i, y=1) and logging every write
  task automatic run_cycles(input int n, input int n_offer, input int second_req_at);
    int   idx = 0;
    logic hs = 1'b0;
    logic prev_busy = clear_busy;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      clear_req   = (c == second_req_at);
      clear_color = 16'h00FF;
      if (hs) idx++;
      if (idx < n_offer) begin
        ray_valid = 1'b1; ray_x = 16'(10 + idx); ray_y = 16'd1; ray_pixel = 16'(32'hB000 + idx);
      end else begin
        ray_valid = 1'b0;
      end
      #1;
      hs = ray_valid && ray_ready;
      if (clear_busy) busy_cyc++;
      if (clear_busy && ray_ready) ready_in_busy++;
      if (prev_busy && !clear_busy && !fall_seen) begin
        fall_seen = 1'b1; fall_we = bram_we; fall_addr = bram_addr; fall_rdy = ray_ready;
      end
      prev_busy = clear_busy;
      if (bram_we) begin
        if (bram_din == exp_color) begin
          if (bram_addr == AB'(clr_wr)) clr_wr++;
          else clr_bad++;
        end else begin
          rw_addr.push_back(bram_addr);
          rw_din.push_back(bram_din);
        end
      end
    end
    clear_req = 1'b0;
    ray_valid = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int   wr_idx;
    int   gap;
    logic found;

    vecs[0] = '{16'd3,   16'd2,   16'h0ABC, 1'b1, 18'd1027};
    vecs[1] = '{16'd0,   16'd0,   16'h1234, 1'b1, 18'd0};
    vecs[2] = '{16'd511, 16'd3,   16'hFFFF, 1'b1, 18'd2047};
    vecs[3] = '{16'd512, 16'd0,   16'h2222, 1'b0, 18'd0};
    vecs[4] = '{16'd0,   16'd384, 16'h3333, 1'b0, 18'd0};
    vecs[5] = '{16'd100, 16'd1,   16'h5555, 1'b1, 18'd612};

    // Reset state
    #1;
    check("rst_busy",  32'(clear_busy), 32'd0);
    check("rst_ready", 32'(ray_ready),  32'd0);
    check("rst_we",    32'(bram_we),    32'd0);
    check("rst_addr",  32'(bram_addr),  32'd0);
    check("rst_din",   32'(bram_din),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rel_ready", 32'(ray_ready), 32'd1);
`ifdef PWA_STATS_EN
    check("rst_frame_pixels", 32'(frame_pixels), 32'd0);
    check("rst_oob",          32'(oob_count),    32'd0);
`endif

    // Table of isolated pixels, including both out-of-range cases
    for (int i = 0; i < 6; i++) send_vec(vecs[i], $sformatf("vec%0d", i));
`ifdef PWA_STATS_EN
    check("vec_frame_pixels", 32'(frame_pixels), 32'd4);
    check("vec_oob",          32'(oob_count),    32'd2);
`endif

    // Burst of 8 back-to-back pixels
    wr_idx = 0; gap = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c < 8) begin
        ray_valid = 1'b1; ray_x = 16'(c * 7); ray_y = 16'(c % 4); ray_pixel = 16'(32'hA000 + c);
      end else begin
        ray_valid = 1'b0;
      end
      #1;
      if (c < 8) check($sformatf("burst_ready%0d", c), 32'(ray_ready), 32'd1);
      if (bram_we) begin
        if (wr_idx < 8) begin
          check($sformatf("burst_addr%0d", wr_idx), 32'(bram_addr), 32'((wr_idx % 4) * FW + wr_idx * 7));
          check($sformatf("burst_din%0d", wr_idx),  32'(bram_din),  32'hA000 + 32'(wr_idx));
        end
        wr_idx++;
      end else if (wr_idx > 0 && wr_idx < 8) begin
        gap++;
      end
    end
    check("burst_writes", 32'(wr_idx), 32'd8);
    check("burst_gaps",   32'(gap),    32'd0);

    // Full clear with an ignored second request mid-clear
    clear_stats();
    exp_color = 16'h0F00;
    @(negedge clk);
    clear_req = 1'b1; clear_color = 16'h0F00;
    #1;
    check("clr_busy_before", 32'(clear_busy), 32'd0);
    run_cycles(int'(NPIX) + 20, 0, 500);
    check("clr_busy_cycles",   32'(busy_cyc),       32'(NPIX));
    check("clr_writes",        32'(clr_wr),         32'(NPIX));
    check("clr_bad_addr",      32'(clr_bad),        32'd0);
    check("clr_other_writes",  32'(rw_addr.size()), 32'd0);
    check("clr_fall_seen",     32'(fall_seen),      32'd1);
    check("clr_fall_we",       32'(fall_we),        32'd1);
    check("clr_fall_addr",     32'(fall_addr),      32'(NPIX - 1));
    check("clr_fall_ready",    32'(fall_rdy),       32'd1);
    check("clr_ready_in_busy", 32'(ready_in_busy),  32'd0);
`ifdef PWA_STATS_EN
    check("clr_frame_pixels",  32'(frame_pixels),   32'd0);
`endif

    // Flush of pending entry, clear-vs-handshake priority, backpressure during clear
    clear_stats();
    @(negedge clk);
    ray_valid = 1'b1; ray_x = 16'd5; ray_y = 16'd0; ray_pixel = 16'hC001;
    @(negedge clk);
    ray_x = 16'd6; ray_pixel = 16'hC002;
    @(negedge clk);
    ray_x = 16'd10; ray_y = 16'd1; ray_pixel = 16'hB000;
    clear_req = 1'b1; clear_color = 16'h0F00;
    #1;
    check("bp_ready_on_clear", 32'(ray_ready), 32'd0);
    run_cycles(int'(NPIX) + 40, 5, -1);
    check("bp_busy_cycles",   32'(busy_cyc),       32'(NPIX));
    check("bp_clr_writes",    32'(clr_wr),         32'(NPIX));
    check("bp_clr_bad",       32'(clr_bad),        32'd0);
    check("bp_ready_in_busy", 32'(ready_in_busy),  32'd0);
    check("bp_ray_writes",    32'(rw_addr.size()), 32'd6);
    if (rw_addr.size() == 6) begin
      check("bp_pre_addr", 32'(rw_addr[0]), 32'd5);
      check("bp_pre_din",  32'(rw_din[0]),  32'hC001);
      for (int k = 0; k < 5; k++) begin
        check($sformatf("bp_addr%0d", k), 32'(rw_addr[k+1]), 32'(FW + 10 + k));
        check($sformatf("bp_din%0d", k),  32'(rw_din[k+1]),  32'hB000 + 32'(k));
      end
    end
`ifdef PWA_STATS_EN
    check("bp_frame_pixels", 32'(frame_pixels), 32'd5);
    check("bp_oob",          32'(oob_count),    32'd2);
`endif

    // Reset in the middle of a clear
    @(negedge clk);
    clear_req = 1'b1; clear_color = 16'h0F00;
    @(negedge clk);
    clear_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1100 && !found; c++) begin
      @(negedge clk); #1;
      if (bram_we && bram_addr == AB'(1000)) found = 1'b1;
    end
    check("rst_mid_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_we",    32'(bram_we),    32'd0);
    check("rst_mid_busy",  32'(clear_busy), 32'd0);
    check("rst_mid_addr",  32'(bram_addr),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_ready", 32'(ray_ready),  32'd1);
    check("rst_mid_busy2", 32'(clear_busy), 32'd0);
    check("rst_mid_we2",   32'(bram_we),    32'd0);
    send_vec('{16'd7, 16'd3, 16'h7777, 1'b1, 18'd1543}, "post_rst");
    clear_stats();
    exp_color = 16'h0F00;
    run_cycles(6, 0, -1);
    check("post_rst_idle_writes", 32'(rw_addr.size() + clr_wr), 32'd0);
    check("post_rst_idle_busy",   32'(busy_cyc),                32'd0);
`ifdef PWA_STATS_EN
    check("post_rst_frame_pixels", 32'(frame_pixels), 32'd1);
    check("post_rst_oob",          32'(oob_count),    32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
